dct_block_sched: RTL and testbench

- Schedules one shared 2D DCT engine between N_REQ block requesters, e.g. Y/Cb/Cr block buffers.
- The engine takes 17 clocks from enable-high to result, and drops to pixel passthrough when enable falls.
- This block arbitrates round-robin and drives the engine enable.
- It holds the grant so the winner keeps its pixel block stable through the row phase, then emits a one-cycle result strobe tagged with the winner id.
- It sits between the block buffers, the DCT engine (pixel mux driven by sel_id) and the quantiser.

---
 rtl/jpeg_enc_pkg.sv | 17 +
 rtl/dct_block_sched_rr_arbiter.sv | 30 +++
 rtl/dct_block_sched.sv | 118 +++++++++++
 tb/tb_dct_block_sched.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_enc_pkg.sv
// Shared JPEG-encoder constants and enums: DCT engine timing, requester ids, scheduler states.
package jpeg_enc_pkg;
  localparam int DCT_ENG_LAT = 17;
  localparam int DCT_ROW_CYC = 8;

  typedef enum logic [1:0] {
    ID_Y  = 2'd0,
    ID_CB = 2'd1,
    ID_CR = 2'd2
  } req_id_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAP  = 2'd2
  } sched_state_e;
endpackage

// File: rtl/dct_block_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set request at or after i_ptr (circular).
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_id,
  output logic             o_vld
);
  logic [ID_W:0] w_idx;

  always_comb begin
    o_gnt = '0;
    o_id  = '0;
    o_vld = 1'b0;
    w_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // i_ptr < N_REQ, so one conditional subtract is enough for the wrap
      w_idx = {1'b0, i_ptr} + (ID_W+1)'(i);
      if (w_idx >= (ID_W+1)'(N_REQ)) w_idx = w_idx - (ID_W+1)'(N_REQ);
      if (!o_vld && i_req[w_idx[ID_W-1:0]]) begin
        o_vld                    = 1'b1;
        o_gnt[w_idx[ID_W-1:0]]   = 1'b1;
        o_id                     = w_idx[ID_W-1:0];
      end
    end
  end
endmodule

// File: rtl/dct_block_sched.sv
// dct_block_sched: round-robin launch of one shared DCT engine; res_valid 17 cycles after eng_enable rises.
// sink_ready gates launch only, no backpressure after launch; DCT_SCHED_STATS_EN adds block/busy counters.
module dct_block_sched
  import jpeg_enc_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int ID_W    = 2,
  parameter int ENG_LAT = DCT_ENG_LAT,
  parameter int ROW_CYC = DCT_ROW_CYC
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_sched_en,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_sink_ready,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_sel_id,
  output logic             o_eng_enable,
  output logic             o_res_valid,
  output logic [ID_W-1:0]  o_res_id,
  output logic             o_busy,
  output logic [15:0]      o_blk_count,
  output logic [31:0]      o_busy_cycles
);
  localparam int CNT_W = $clog2(ENG_LAT + 1);

  sched_state_e     r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [ID_W-1:0]  r_sel_id, w_sel_id_nxt;
  logic [ID_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [N_REQ-1:0] w_arb_gnt;
  logic [ID_W-1:0]  w_arb_id;
  logic             w_arb_vld;
  logic             w_launch;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .i_req (i_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_arb_gnt),
    .o_id  (w_arb_id),
    .o_vld (w_arb_vld)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_sel_id <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sel_id <= w_sel_id_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sel_id_nxt = r_sel_id;
    w_rr_ptr_nxt = r_rr_ptr;
    w_launch     = i_sched_en & i_sink_ready & w_arb_vld;
    o_grant      = '0;
    o_eng_enable = 1'b0;
    o_busy       = 1'b0;
    o_res_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_launch) begin
          w_state_nxt  = RUN;
          w_cnt_nxt    = '0;
          w_sel_id_nxt = w_arb_id;
          w_rr_ptr_nxt = (w_arb_id == ID_W'(N_REQ - 1)) ? '0 : w_arb_id + 1'b1;
        end
      end
      RUN: begin
        o_eng_enable = 1'b1;
        o_busy       = 1'b1;
        w_cnt_nxt    = r_cnt + 1'b1;
        // grant spans the engine row phase only; pixels are free afterwards
        if (r_cnt < CNT_W'(ROW_CYC)) o_grant[r_sel_id] = 1'b1;
        if (r_cnt == CNT_W'(ENG_LAT - 1)) w_state_nxt = CAP;
      end
      CAP: begin
        o_eng_enable = 1'b1;
        o_busy       = 1'b1;
        o_res_valid  = 1'b1;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_sel_id = r_sel_id;
  assign o_res_id = r_sel_id;

`ifdef DCT_SCHED_STATS_EN
  logic [15:0] r_blk_count;
  logic [31:0] r_busy_cycles;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_blk_count   <= '0;
      r_busy_cycles <= '0;
    end else begin
      if (o_res_valid) r_blk_count <= r_blk_count + 1'b1;
      if (o_busy && (r_busy_cycles != '1)) r_busy_cycles <= r_busy_cycles + 1'b1;
    end
  end

  assign o_blk_count   = r_blk_count;
  assign o_busy_cycles = r_busy_cycles;
`else
  assign o_blk_count   = '0;
  assign o_busy_cycles = '0;
`endif
endmodule

// File: tb/tb_dct_block_sched.sv
// Bench for dct_block_sched: table of single-block launches plus stream, stall, sched_en and reset sequences.
module tb_dct_block_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sched_en;
  logic [2:0]  req;
  logic        sink_ready;
  logic [2:0]  grant;
  logic [1:0]  sel_id;
  logic        eng_enable;
  logic        res_valid;
  logic [1:0]  res_id;
  logic        busy;
  logic [15:0] blk_count;
  logic [31:0] busy_cycles;

  typedef struct {
    logic [1:0] id;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [2:0] req;
    logic [1:0] id;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

`ifdef DCT_SCHED_STATS_EN
  localparam int EXP_BLK  = 5;
  localparam int EXP_BUSY = 90;
`else
  localparam int EXP_BLK  = 0;
  localparam int EXP_BUSY = 0;
`endif

  always #5 clk = ~clk;

  dct_block_sched dut (
    .i_clock       (clk),
    .i_reset_n     (rst_n),
    .i_sched_en    (sched_en),
    .i_req         (req),
    .i_sink_ready  (sink_ready),
    .o_grant       (grant),
    .o_sel_id      (sel_id),
    .o_eng_enable  (eng_enable),
    .o_res_valid   (res_valid),
    .o_res_id      (res_id),
    .o_busy        (busy),
    .o_blk_count   (blk_count),
    .o_busy_cycles (busy_cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: land on the falling edge, then score any result strobe.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (res_valid) begin
      if (sb.size() == 0) begin
        chk("res_unexpected", 32'(res_id), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("res_id", 32'(res_id), 32'(e.id));
        chk("res_cycle", cyc, e.cyc);
      end
    end
    if (grant != 3'b000) chk("grant_onehot", 32'($onehot(grant)), 1);
  endtask

  task automatic push(input logic [1:0] id, input int at);
    exp_t e;
    e.id  = id;
    e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic run_to_idle();
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("idle_reached", 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 3'b000;
    sink_ready = 1'b1;
    sched_en = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Called at c0; counts enable and grant cycles until enable falls.
  task automatic watch_block(input logic [2:0] g, input bit drop, output int en_cnt, output int g_cnt);
    int n = 0;
    en_cnt = 0;
    g_cnt = 0;
    while (eng_enable && n < 40) begin
      en_cnt++;
      if (grant == g) g_cnt++;
      if (drop && n == 8) req = 3'b000;
      tick();
      n++;
    end
  endtask

  task automatic run_stream(input logic [2:0] r, input int nblk, input bit rotate);
    int l;
    req = r;
    tick();
    l = cyc;
    chk("stream_launch", 32'(eng_enable), 1);
    for (int i = 0; i < nblk; i++) push(rotate ? 2'(i % 3) : 2'd0, l + 19 * i + 17);
    repeat ((nblk - 1) * 19 + 8) tick();
    req = 3'b000;
    run_to_idle();
    chk("stream_drained", sb.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 300000");
    $fatal(1, "timeout");
  end

  initial begin
    int l0, en_c, g_c, any_en;
    logic [2:0] g;

    tbl[0] = '{3'b001, 2'd0};
    tbl[1] = '{3'b001, 2'd0};
    tbl[2] = '{3'b111, 2'd1};
    tbl[3] = '{3'b011, 2'd0};
    tbl[4] = '{3'b100, 2'd2};
    tbl[5] = '{3'b110, 2'd1};
    tbl[6] = '{3'b101, 2'd2};
    tbl[7] = '{3'b010, 2'd1};

    rst_n = 1'b0;
    req = 3'b000;
    sink_ready = 1'b0;
    sched_en = 1'b0;
    repeat (2) tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_sel_id", 32'(sel_id), 0);
    chk("rst_eng_enable", 32'(eng_enable), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_blk_count", 32'(blk_count), 0);
    chk("rst_busy_cycles", busy_cycles, 0);
    do_reset();

    // single requester held: 8 grant cycles, 18 enable cycles, 19-cycle launch period
    req = 3'b001;
    tick();
    l0 = cyc;
    push(2'd0, l0 + 17);
    watch_block(3'b001, 1'b0, en_c, g_c);
    chk("t1_enable_cycles", en_c, 18);
    chk("t1_grant_cycles", g_c, 8);
    tick();
    chk("t1_period", cyc - l0, 19);
    chk("t1_sel_id2", 32'(sel_id), 0);
    push(2'd0, cyc + 17);
    watch_block(3'b001, 1'b1, en_c, g_c);
    run_to_idle();

    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req;
      tick();
      g = 3'b001 << tbl[i].id;
      chk("tbl_sel_id", 32'(sel_id), 32'(tbl[i].id));
      chk("tbl_grant", 32'(grant), 32'(g));
      push(tbl[i].id, cyc + 17);
      repeat (8) tick();
      chk("tbl_grant_clear", 32'(grant), 0);
      req = 3'b000;
      run_to_idle();
    end

    // all three requesting continuously: ids rotate 0,1,2 every 19 cycles
    do_reset();
    run_stream(3'b111, 6, 1'b1);

    // sink not ready holds off launch
    sink_ready = 1'b0;
    req = 3'b010;
    repeat (4) begin
      tick();
      chk("stall_no_enable", 32'(eng_enable), 0);
    end
    sink_ready = 1'b1;
    tick();
    chk("stall_release_en", 32'(eng_enable), 1);
    chk("stall_release_sel", 32'(sel_id), 1);
    push(2'd1, cyc + 17);
    repeat (8) tick();
    req = 3'b000;
    run_to_idle();

    // sched_en dropped mid-block: block completes, no relaunch
    req = 3'b100;
    tick();
    chk("en_drop_sel", 32'(sel_id), 2);
    push(2'd2, cyc + 17);
    repeat (5) tick();
    sched_en = 1'b0;
    repeat (13) tick();
    chk("en_drop_idle", 32'(busy), 0);
    any_en = 0;
    repeat (8) begin
      tick();
      if (eng_enable) any_en = 1;
    end
    chk("en_drop_no_launch", any_en, 0);
    req = 3'b000;
    sched_en = 1'b1;
    chk("en_drop_drained", sb.size(), 0);

    // async reset at c10 clears outputs immediately; sequence restarts from c0
    req = 3'b001;
    tick();
    repeat (10) tick();
    chk("rst_mid_busy_before", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_grant", 32'(grant), 0);
    chk("rst_mid_enable", 32'(eng_enable), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_res_valid", 32'(res_valid), 0);
    chk("rst_mid_sel_id", 32'(sel_id), 0);
    tick();
    rst_n = 1'b1;
    tick();
    push(2'd0, cyc + 17);
    watch_block(3'b001, 1'b1, en_c, g_c);
    chk("rst_restart_enable_cycles", en_c, 18);
    chk("rst_restart_grant_cycles", g_c, 8);
    run_to_idle();

    // statistics over five blocks
    do_reset();
    run_stream(3'b001, 5, 1'b0);
    chk("stats_blk_count", 32'(blk_count), EXP_BLK);
    chk("stats_busy_cycles", busy_cycles, EXP_BUSY);

    chk("final_sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
